segled_scan_ctrl: RTL and testbench
===================================

Name: segled_scan_ctrl

Overview:
Scan controller for the 6-digit multiplexed seven-segment display on the 50 MHz board. It holds a software-writable shadow digit buffer and commits it to the active buffer only at frame boundaries, so the display never tears. It time-multiplexes the digits one at a time, applies 16-level PWM brightness with a built-in anti-ghosting blank, and optionally blanks leading zeros. It drives SEG_DATA/SEG_EN directly and replaces hand-coded per-design scan logic.

Parameters:
SUB_CYCLES, 3125, clock cycles per PWM sub-tick; one digit slot = 16*SUB_CYCLES cycles (1 ms at default), one frame = 6 slots.
CNT_W, 12, width of the sub-tick cycle counter; must hold SUB_CYCLES-1.

Ports:
CLK_50M  in  1  system clock, 50 MHz
RST  in  1  synchronous reset, active-high
WR_EN  in  1  shadow-buffer write strobe
WR_ADDR  in  3  digit index 0..5; 0 = leftmost/most significant (SEG1)
WR_DATA  in  5  [3:0] hex value, [4] decimal point
COMMIT  in  1  one-cycle request to copy shadow->active at next frame boundary
BRIGHT  in  4  on-time in sub-ticks per slot (0 = dark, 15 = 15/16)
LZB  in  1  leading-zero blanking enable
COMMIT_PENDING  out  1  commit requested, not yet applied
FRAME_DONE  out  1  one-cycle pulse at start of each frame
SEG_DATA  out  8  segments, active-high; [6:0] = g..a, [7] = dp
SEG_EN  out  6  digit enables, active-low one-cold; bit n = digit n

Behaviour:
- Only CLK_50M is used as a clock. RST is synchronous and active-high.
- Reset values:
  - SEG_EN = 6'b111111, SEG_DATA = 8'h00, COMMIT_PENDING = 0, FRAME_DONE = 0.
  - Shadow and active buffers are all 5'h00.
  - sub_cnt = 0, subtick = 0, digit = 0.
- Counters:
  - sub_cnt runs 0..SUB_CYCLES-1.
  - On wrap, subtick advances 0..15.
  - On subtick 15 wrap, digit advances 0..5, then back to 0.
- Frame boundary: the cycle with digit = 5, subtick = 15, sub_cnt = SUB_CYCLES-1.
- BRIGHT is latched into bright_q at the first cycle of every slot. Changes inside a slot take effect at the next slot.
- Slot output, registered with 1-cycle latency from the counters:
  - The digit is lit when subtick < bright_q and the digit is not blanked.
  - Lit: SEG_EN = ~(6'b1 << digit), SEG_DATA = font(active[digit][3:0]) | active[digit][4]<<7.
  - Not lit: SEG_EN = 6'b111111, SEG_DATA = 8'h00.
  - Subtick 15 is therefore always dark (guard interval).
- Font, 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Leading-zero blanking (LZB = 1):
  - Digits 0..4 whose active value is 0 with dp clear are blanked, starting from digit 0, until the first digit that is nonzero or has dp set.
  - Digit 5 is never blanked.
  - LZB is evaluated combinationally from the active buffer.
- Writes:
  - WR_EN with WR_ADDR <= 5 writes WR_DATA into shadow[WR_ADDR] at the clock edge.
  - WR_ADDR 6 or 7 is ignored with no side effects.
  - Writes are always accepted; there is no backpressure.
- Commit:
  - COMMIT sets COMMIT_PENDING on the next edge.
  - At the frame-boundary edge, if pending is already set: active <= shadow (all 6 digits at once) and pending clears.
  - COMMIT asserted on the boundary cycle itself sets pending and is applied at the following boundary.
  - A write in the same cycle as COMMIT, or while pending, is included in the commit.
  - Repeated COMMITs while pending merge into one.
- FRAME_DONE is high for exactly one cycle, the cycle after the boundary edge. This is the same cycle the first digit-0 output of the new frame appears, and the same cycle committed data first becomes visible.
- Reset mid-frame: all state returns to reset values on the next edge, and any pending commit is discarded.

Decomposition:
- Package segled_pkg holds:
  - NUM_DIGITS = 6 and SUBTICKS = 16.
  - SEG_OFF = 8'h00 and EN_OFF = 6'b111111.
  - The 16-entry hex font constant table.
  - The digit-entry typedef (5 bits: dp, hex[3:0]).
- One sub-module, segled_hex_font: a combinational 4-bit to 7-segment lookup using the package table, instantiated once on the selected digit.

Test Plan:
- Reset check (SUB_CYCLES = 4): after RST, SEG_EN = 3F and SEG_DATA = 00. With BRIGHT = 15 and shadow "012345" committed, after the first FRAME_DONE:
  - digit n shows SEG_EN = ~(1<<n) for 60 cycles, then all-off for 4 cycles;
  - SEG_DATA = 3F, 06, 5B, 4F, 66, 6D in order;
  - frame length is 384 cycles.
- Commit timing: write shadow = "ABCDEF", pulse COMMIT mid-frame.
  - COMMIT_PENDING = 1 until the boundary.
  - Old digits continue until FRAME_DONE; then 77, 7C, 39, 5E, 79, 71 appear and pending = 0.
  - COMMIT on the boundary cycle is applied one frame later.
- Brightness:
  - BRIGHT = 0 gives SEG_EN = 3F for the whole frame.
  - BRIGHT = 4 gives each digit 16 lit cycles per 64-cycle slot.
  - Changing BRIGHT mid-slot changes the duty only from the next slot.
- Leading-zero blanking: active = 0,0,0,1,0,7 with LZB = 1.
  - Digits 0..2 stay dark; digit 4 shows 3F.
  - With dp set on digit 1, digit 1 shows BF and digit 2 shows 3F.
  - All zeros shows only digit 5.
- Invalid address and reset: WR_ADDR = 6 or 7 writes followed by COMMIT leave the display unchanged. RST asserted mid-slot with pending set gives reset values next cycle, pending = 0, and the scan restarting at digit 0.

Source files
------------

// File: rtl/segled_scan_ctrl_pkg.sv
// rtl/segled_scan_ctrl_pkg.sv - shared constants, font table and digit type for the scan controller
package segled_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int SUBTICKS   = 16;

    localparam logic [7:0] SEG_OFF = 8'h00;
    localparam logic [5:0] EN_OFF  = 6'b111111;

    // Segment patterns g..a for hex 0..F; entry 0 is the rightmost element
    localparam logic [15:0][6:0] FONT_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic       dp;
        logic [3:0] hex;
    } digit_t;

endpackage

// File: rtl/segled_scan_ctrl_if.sv
// rtl/segled_scan_ctrl_if.sv - host write/commit bus and display outputs of the scan controller
interface segled_scan_ctrl_if;
    logic       WR_EN;
    logic [2:0] WR_ADDR;
    logic [4:0] WR_DATA;
    logic       COMMIT;
    logic [3:0] BRIGHT;
    logic       LZB;
    logic       COMMIT_PENDING;
    logic       FRAME_DONE;
    logic [7:0] SEG_DATA;
    logic [5:0] SEG_EN;

    modport master (
        output WR_EN, WR_ADDR, WR_DATA, COMMIT, BRIGHT, LZB,
        input  COMMIT_PENDING, FRAME_DONE, SEG_DATA, SEG_EN
    );

    modport slave (
        input  WR_EN, WR_ADDR, WR_DATA, COMMIT, BRIGHT, LZB,
        output COMMIT_PENDING, FRAME_DONE, SEG_DATA, SEG_EN
    );
endinterface

// File: rtl/segled_hex_font.sv
// rtl/segled_hex_font.sv - combinational hex to seven-segment lookup
module segled_hex_font
    import segled_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = FONT_TABLE[hex_i];

endmodule

// File: rtl/segled_scan_ctrl.sv
// rtl/segled_scan_ctrl.sv - 6-digit multiplexed seven-segment scan controller with PWM and tear-free commit
module segled_scan_ctrl
    import segled_pkg::*;
#(
    parameter int SUB_CYCLES = 3125,
    parameter int CNT_W      = 12
) (
    input  logic             CLK_50M,
    input  logic             RST,
    segled_scan_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] SUB_LAST   = CNT_W'(SUB_CYCLES - 1);
    localparam logic [2:0]       DIGIT_LAST = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] sub_cnt_q, sub_cnt_d;
    logic [3:0]       subtick_q, subtick_d;
    logic [2:0]       digit_q, digit_d;
    logic [3:0]       bright_q, bright_d;
    logic             pending_q, pending_d;
    logic             frame_done_q;
    logic [7:0]       seg_data_q, seg_data_d;
    logic [5:0]       seg_en_q, seg_en_d;

    digit_t [NUM_DIGITS-1:0] shadow_q, shadow_d;
    digit_t [NUM_DIGITS-1:0] active_q, active_d;

    logic                  sub_wrap, slot_wrap, boundary;
    logic [NUM_DIGITS-1:0] blank_d;
    logic                  still_zero;
    logic                  lit;
    digit_t                cur_digit;
    logic [6:0]            cur_font;

    // Scan counters and the per-slot brightness latch
    always_comb begin
        sub_wrap  = (sub_cnt_q == SUB_LAST);
        slot_wrap = sub_wrap && (subtick_q == 4'(SUBTICKS - 1));
        boundary  = slot_wrap && (digit_q == DIGIT_LAST);

        sub_cnt_d = sub_wrap ? '0 : sub_cnt_q + 1'b1;
        subtick_d = sub_wrap ? subtick_q + 4'd1 : subtick_q;
        digit_d   = digit_q;
        if (slot_wrap) begin
            digit_d = (digit_q == DIGIT_LAST) ? 3'd0 : digit_q + 3'd1;
        end
        // The edge entering a slot samples BRIGHT; the whole slot then uses it
        bright_d = slot_wrap ? bus.BRIGHT : bright_q;
    end

    // Shadow writes, commit request tracking and the frame-boundary copy
    always_comb begin
        shadow_d = shadow_q;
        if (bus.WR_EN && (bus.WR_ADDR <= DIGIT_LAST)) begin
            shadow_d[bus.WR_ADDR] = digit_t'(bus.WR_DATA);
        end
        active_d = active_q;
        if (boundary && pending_q) begin
            active_d = shadow_d;
        end
        // A commit on the boundary cycle re-arms for the following frame
        if (bus.COMMIT) begin
            pending_d = 1'b1;
        end else if (boundary) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Leading-zero blanking over the buffer that will be on display next cycle
    always_comb begin
        blank_d    = '0;
        still_zero = bus.LZB;
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            if (still_zero && (active_d[i] == '0)) begin
                blank_d[i] = 1'b1;
            end else begin
                still_zero = 1'b0;
            end
        end
    end

    segled_hex_font u_font (
        .hex_i (cur_digit.hex),
        .seg_o (cur_font)
    );

    // Output pattern is built from next-state values so the registered drive lines up with the counters
    always_comb begin
        cur_digit  = active_d[digit_d];
        lit        = (subtick_d < bright_d) && !blank_d[digit_d];
        seg_en_d   = EN_OFF;
        seg_data_d = SEG_OFF;
        if (lit) begin
            seg_en_d   = ~(6'b000001 << digit_d);
            seg_data_d = {cur_digit.dp, cur_font};
        end
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            sub_cnt_q    <= '0;
            subtick_q    <= '0;
            digit_q      <= '0;
            bright_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_data_q   <= SEG_OFF;
            seg_en_q     <= EN_OFF;
            shadow_q     <= '0;
            active_q     <= '0;
        end else begin
            sub_cnt_q    <= sub_cnt_d;
            subtick_q    <= subtick_d;
            digit_q      <= digit_d;
            bright_q     <= bright_d;
            pending_q    <= pending_d;
            frame_done_q <= boundary;
            seg_data_q   <= seg_data_d;
            seg_en_q     <= seg_en_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
        end
    end

    assign bus.COMMIT_PENDING = pending_q;
    assign bus.FRAME_DONE     = frame_done_q;
    assign bus.SEG_DATA       = seg_data_q;
    assign bus.SEG_EN         = seg_en_q;

endmodule

// File: tb/tb_segled_scan_ctrl.sv
// tb/tb_segled_scan_ctrl.sv - self-checking bench for segled_scan_ctrl against a frame-arithmetic model
module tb_segled_scan_ctrl;

    localparam int S     = 4;
    localparam int SLOT  = 16 * S;
    localparam int FRAME = 6 * SLOT;

    logic clk;
    logic rst;

    segled_scan_ctrl_if bus ();

    segled_scan_ctrl #(.SUB_CYCLES(S), .CNT_W(4)) dut (
        .CLK_50M (clk),
        .RST     (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] fnt [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int         passed = 0;
    int         total  = 0;
    int         k      = 0;
    int         cyc    = 0;
    int         last_fd = -1;
    int         m_bright = 0;
    bit         m_pend = 0;
    logic [4:0] m_shadow [6];
    logic [4:0] m_active [6];
    logic [5:0] e_en;
    logic [7:0] e_data;
    logic       e_fd;
    logic       e_pend;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Advance the model by one clock from the current inputs, clock the DUT, then compare
    task automatic step();
        bit         bnd;
        bit         blanked;
        bit         lit;
        int         d;
        int         s;
        logic [4:0] cur;
        logic [5:0] one;
        if (rst) begin
            k = 0;
            for (int i = 0; i < 6; i++) begin
                m_shadow[i] = 5'h00;
                m_active[i] = 5'h00;
            end
            m_pend   = 0;
            m_bright = 0;
            e_en     = 6'h3F;
            e_data   = 8'h00;
            e_fd     = 1'b0;
            last_fd  = -1;
        end else begin
            bnd = ((k % FRAME) == FRAME - 1);
            if (bus.WR_EN && bus.WR_ADDR <= 3'd5) m_shadow[bus.WR_ADDR] = bus.WR_DATA;
            if (bnd && m_pend) begin
                for (int i = 0; i < 6; i++) m_active[i] = m_shadow[i];
            end
            if (bus.COMMIT) m_pend = 1;
            else if (bnd) m_pend = 0;
            k++;
            if ((k % SLOT) == 0) m_bright = int'(bus.BRIGHT);
            e_fd = ((k % FRAME) == 0);
            d = (k / SLOT) % 6;
            s = (k / S) % 16;
            blanked = bus.LZB && (d < 5);
            for (int i = 0; i <= d; i++) begin
                if (m_active[i] != 5'h00) blanked = 0;
            end
            lit = (s < m_bright) && !blanked;
            cur = m_active[d];
            one = 6'b000001;
            e_en   = lit ? ~(one << d) : 6'h3F;
            e_data = lit ? {cur[4], fnt[cur[3:0]]} : 8'h00;
        end
        e_pend = m_pend;
        @(posedge clk);
        #1;
        cyc++;
        chk("seg_en", {2'b00, bus.SEG_EN}, {2'b00, e_en});
        chk("seg_data", bus.SEG_DATA, e_data);
        chk("frame_done", {7'd0, bus.FRAME_DONE}, {7'd0, e_fd});
        chk("commit_pending", {7'd0, bus.COMMIT_PENDING}, {7'd0, e_pend});
        if (bus.FRAME_DONE === 1'b1) begin
            if (last_fd >= 0) chk("frame_len", 8'((cyc - last_fd) / 2), 8'(FRAME / 2));
            last_fd = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [2:0] a, input logic [4:0] v);
        bus.WR_EN   = 1'b1;
        bus.WR_ADDR = a;
        bus.WR_DATA = v;
        step();
        bus.WR_EN   = 1'b0;
    endtask

    task automatic commit();
        bus.COMMIT = 1'b1;
        step();
        bus.COMMIT = 1'b0;
    endtask

    task automatic to_boundary();
        for (int i = 0; i < FRAME && (k % FRAME) != FRAME - 1; i++) step();
    endtask

    task automatic load(input logic [4:0] v0, input logic [4:0] v1, input logic [4:0] v2,
                        input logic [4:0] v3, input logic [4:0] v4, input logic [4:0] v5);
        wr(3'd0, v0); wr(3'd1, v1); wr(3'd2, v2);
        wr(3'd3, v3); wr(3'd4, v4); wr(3'd5, v5);
    endtask

    initial begin
        rst         = 1'b1;
        bus.WR_EN   = 1'b0;
        bus.WR_ADDR = 3'd0;
        bus.WR_DATA = 5'd0;
        bus.COMMIT  = 1'b0;
        bus.BRIGHT  = 4'd15;
        bus.LZB     = 1'b0;
        run(3);
        rst = 1'b0;

        load(5'h0, 5'h1, 5'h2, 5'h3, 5'h4, 5'h5);
        commit();
        run(2 * FRAME);

        run(100);
        load(5'hA, 5'hB, 5'hC, 5'hD, 5'hE, 5'hF);
        commit();
        run(FRAME);

        load(5'h1, 5'h2, 5'h3, 5'h4, 5'h5, 5'h6);
        to_boundary();
        commit();
        run(FRAME + 10);

        bus.BRIGHT = 4'd0;
        run(FRAME);
        bus.BRIGHT = 4'd4;
        run(FRAME);
        run(SLOT / 2 + 3);
        bus.BRIGHT = 4'd9;
        run(2 * SLOT);

        bus.BRIGHT = 4'd15;
        bus.LZB    = 1'b1;
        load(5'h0, 5'h0, 5'h0, 5'h1, 5'h0, 5'h7);
        commit();
        run(FRAME + 40);
        wr(3'd1, 5'h10);
        commit();
        run(FRAME + 40);
        load(5'h0, 5'h0, 5'h0, 5'h0, 5'h0, 5'h0);
        commit();
        run(FRAME + 40);
        bus.LZB = 1'b0;

        load(5'h3, 5'h1, 5'h4, 5'h1, 5'h5, 5'h9);
        commit();
        run(FRAME);
        wr(3'd6, 5'h1F);
        wr(3'd7, 5'h08);
        commit();
        run(FRAME + 20);

        for (int i = 0; i < 6 * FRAME; i++) begin
            bus.WR_EN   = ($urandom_range(0, 15) == 0);
            bus.WR_ADDR = 3'($urandom_range(0, 7));
            bus.WR_DATA = 5'($urandom);
            bus.COMMIT  = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 199) == 0) bus.BRIGHT = 4'($urandom);
            if ($urandom_range(0, 299) == 0) bus.LZB = ~bus.LZB;
            step();
        end
        bus.WR_EN  = 1'b0;
        bus.COMMIT = 1'b0;

        run(SLOT + 17);
        wr(3'd2, 5'h18);
        commit();
        run(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(FRAME + 5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
